// File: rtl/sobel_grad_core.sv
// sobel_grad_core: four-stage pipelined Sobel L1 gradient engine with
// valid/ready flow control, per-beat output shaping and a per-frame
// edge-pixel counter.
// Optional feature macro: SOBEL_DIR_EN adds the dir_o gradient-direction output.
module sobel_grad_core #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9*DATA_W-1:0]   win_i,
    input  logic [1:0]            mode_i,
    input  logic [DATA_W+2:0]     thresh_i,
    input  logic                  last_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_W-1:0]     pix_o,
    output logic                  last_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [CNT_W-1:0]      edge_cnt_o,
    output logic                  cnt_valid_o
`ifdef SOBEL_DIR_EN
    ,
    output logic [1:0]            dir_o
`endif
);

    localparam int GW = DATA_W + 2;
    localparam int MW = DATA_W + 3;
    localparam logic [DATA_W-1:0] MAX = '1;

    // Whole pipe advances together; a stalled output freezes every stage.
    logic en;
    assign en         = !out_valid_o || out_ready_i;
    assign in_ready_o = en;

    logic hs;
    assign hs = out_valid_o && out_ready_i;

    // ---------------- S1: partial sums ----------------
    logic [GW-1:0] tap [9];
    for (genvar k = 0; k < 9; k++) begin : g_tap
        assign tap[k] = {2'b00, win_i[k*DATA_W +: DATA_W]};
    end

    logic [GW-1:0] gxp_c, gxn_c, gyp_c, gyn_c;
    assign gxp_c = tap[0] + (tap[3] << 1) + tap[6];
    assign gxn_c = tap[2] + (tap[5] << 1) + tap[8];
    assign gyp_c = tap[0] + (tap[1] << 1) + tap[2];
    assign gyn_c = tap[6] + (tap[7] << 1) + tap[8];

    logic            s1_v, s1_last;
    logic [GW-1:0]   s1_gxp, s1_gxn, s1_gyp, s1_gyn;
    logic [1:0]      s1_mode;
    logic [MW-1:0]   s1_thr;

    // Stage 1 register: partial sums plus the beat's side-band fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s1_gxp  <= '0;
            s1_gxn  <= '0;
            s1_gyp  <= '0;
            s1_gyn  <= '0;
            s1_mode <= '0;
            s1_thr  <= '0;
        end else if (en) begin
            s1_v    <= in_valid_i;
            s1_last <= last_i;
            s1_gxp  <= gxp_c;
            s1_gxn  <= gxn_c;
            s1_gyp  <= gyp_c;
            s1_gyn  <= gyn_c;
            s1_mode <= mode_i;
            s1_thr  <= thresh_i;
        end
    end

    // ---------------- S2: absolute differences ----------------
    logic [GW-1:0] agx_c, agy_c;
    assign agx_c = (s1_gxp >= s1_gxn) ? (s1_gxp - s1_gxn) : (s1_gxn - s1_gxp);
    assign agy_c = (s1_gyp >= s1_gyn) ? (s1_gyp - s1_gyn) : (s1_gyn - s1_gyp);

    logic            s2_v, s2_last;
    logic [GW-1:0]   s2_agx, s2_agy;
    logic [1:0]      s2_mode;
    logic [MW-1:0]   s2_thr;

    // Stage 2 register: gradient magnitudes per axis.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_last <= 1'b0;
            s2_agx  <= '0;
            s2_agy  <= '0;
            s2_mode <= '0;
            s2_thr  <= '0;
        end else if (en) begin
            s2_v    <= s1_v;
            s2_last <= s1_last;
            s2_agx  <= agx_c;
            s2_agy  <= agy_c;
            s2_mode <= s1_mode;
            s2_thr  <= s1_thr;
        end
    end

`ifdef SOBEL_DIR_EN
    logic s2_sx, s2_sy;

    // Gradient signs travel alongside the magnitudes for the direction rule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sx <= 1'b0;
            s2_sy <= 1'b0;
        end else if (en) begin
            s2_sx <= (s1_gxp >= s1_gxn);
            s2_sy <= (s1_gyp >= s1_gyn);
        end
    end
`endif

    // ---------------- S3: magnitude and edge decision ----------------
    logic [MW-1:0] mag_c;
    assign mag_c = {1'b0, s2_agx} + {1'b0, s2_agy};

    logic            s3_v, s3_last, s3_is_edge;
    logic [MW-1:0]   s3_mag;
    logic [1:0]      s3_mode;

    // Stage 3 register: L1 magnitude and threshold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_v       <= 1'b0;
            s3_last    <= 1'b0;
            s3_is_edge <= 1'b0;
            s3_mag     <= '0;
            s3_mode    <= '0;
        end else if (en) begin
            s3_v       <= s2_v;
            s3_last    <= s2_last;
            s3_is_edge <= (mag_c >= s2_thr);
            s3_mag     <= mag_c;
            s3_mode    <= s2_mode;
        end
    end

`ifdef SOBEL_DIR_EN
    logic [1:0] dir_c;
    logic [1:0] s3_dir;

    // Dominant-axis test first, then diagonal quadrant from the signs.
    always_comb begin
        dir_c = 2'd3;
        if ({1'b0, s2_agx} >= {s2_agy, 1'b0})
            dir_c = 2'd0;
        else if ({1'b0, s2_agy} >= {s2_agx, 1'b0})
            dir_c = 2'd1;
        else if (s2_sx == s2_sy)
            dir_c = 2'd2;
    end

    // Direction register aligned with stage 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s3_dir <= '0;
        else if (en)
            s3_dir <= dir_c;
    end
`endif

    // ---------------- S4: output shaping ----------------
    logic [DATA_W-1:0] sat_c, shaped_c;
    assign sat_c = (s3_mag > {3'b000, MAX}) ? MAX : s3_mag[DATA_W-1:0];

    // Mode 3 is not a distinct mode and falls back to saturated magnitude.
    always_comb begin
        shaped_c = sat_c;
        case (s3_mode)
            2'd1:    shaped_c = s3_is_edge ? MAX : '0;
            2'd2:    shaped_c = s3_is_edge ? MAX : sat_c;
            default: shaped_c = sat_c;
        endcase
    end

    logic s4_is_edge;

    // Output register; holds while downstream is not ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
            pix_o       <= '0;
            last_o      <= 1'b0;
            s4_is_edge  <= 1'b0;
        end else if (en) begin
            out_valid_o <= s3_v;
            pix_o       <= shaped_c;
            last_o      <= s3_last;
            s4_is_edge  <= s3_is_edge;
        end
    end

`ifdef SOBEL_DIR_EN
    // Direction output aligned with pix_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dir_o <= '0;
        else if (en)
            dir_o <= s3_dir;
    end
`endif

    // ---------------- edge counter ----------------
    logic [CNT_W-1:0] cnt, cnt_inc;
    assign cnt_inc = (s4_is_edge && (cnt != '1)) ? (cnt + CNT_W'(1)) : cnt;

    // Count edges on output handshakes; publish and clear at end of frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            edge_cnt_o  <= '0;
            cnt_valid_o <= 1'b0;
        end else begin
            cnt_valid_o <= 1'b0;
            if (hs) begin
                if (last_o) begin
                    edge_cnt_o  <= cnt_inc;
                    cnt         <= '0;
                    cnt_valid_o <= 1'b1;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_grad_core.sv
// tb_sobel_grad_core: directed and randomized checks of sobel_grad_core
// against an integer-arithmetic reference model and scoreboard queue.
module tb_sobel_grad_core;

    localparam int DW   = 8;
    localparam int CW   = 4;
    localparam int PMAX = (1 << DW) - 1;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk;
    logic              rst_n;
    logic [9*DW-1:0]   win_i;
    logic [1:0]        mode_i;
    logic [DW+2:0]     thresh_i;
    logic              last_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DW-1:0]     pix_o;
    logic              last_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CW-1:0]     edge_cnt_o;
    logic              cnt_valid_o;
`ifdef SOBEL_DIR_EN
    logic [1:0]        dir_o;
`endif

    sobel_grad_core #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .win_i       (win_i),
        .mode_i      (mode_i),
        .thresh_i    (thresh_i),
        .last_i      (last_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .pix_o       (pix_o),
        .last_o      (last_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .edge_cnt_o  (edge_cnt_o),
        .cnt_valid_o (cnt_valid_o)
`ifdef SOBEL_DIR_EN
        ,
        .dir_o       (dir_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pix;
        bit last;
        bit edg;
        int dir;
    } exp_t;

    exp_t q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // model state for the counter outputs visible in the current cycle
    int m_cnt = 0;
    int m_ec  = 0;
    bit m_cv  = 0;

    bit held = 0;
    int held_pix = 0;
    bit acc = 0;
    bit ov_now = 0;
    int last_pix = 0;
    int last_dir = 0;
    int pulses = 0;
    int n_out = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference: Sobel L1 gradient computed with signed integers.
    function automatic exp_t model(input logic [9*DW-1:0] w, input logic [1:0] m,
                                   input int thr, input bit lst);
        exp_t r;
        int t[9];
        int gx, gy, ax, ay, mag, sat;
        for (int k = 0; k < 9; k++) t[k] = int'(w[k*DW +: DW]);
        gx  = (t[0] + 2*t[3] + t[6]) - (t[2] + 2*t[5] + t[8]);
        gy  = (t[0] + 2*t[1] + t[2]) - (t[6] + 2*t[7] + t[8]);
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        mag = ax + ay;
        sat = (mag > PMAX) ? PMAX : mag;
        r.edg  = (mag >= thr);
        r.last = lst;
        if (m == 2'd1)      r.pix = r.edg ? PMAX : 0;
        else if (m == 2'd2) r.pix = r.edg ? PMAX : sat;
        else                r.pix = sat;
        if (ax >= 2*ay)                 r.dir = 0;
        else if (ay >= 2*ax)            r.dir = 1;
        else if ((gx >= 0) == (gy >= 0)) r.dir = 2;
        else                            r.dir = 3;
        return r;
    endfunction

    // One clock: called just after a negedge with inputs already driven.
    task automatic cyc();
        exp_t e;
        bit next_cv;
        int c;
        #1;
        ov_now = out_valid_o;
        chk("in_ready", in_ready_o, !out_valid_o || out_ready_i);
        chk("cnt_valid", cnt_valid_o, m_cv);
        chk("edge_cnt", edge_cnt_o, m_ec);
        if (cnt_valid_o) pulses++;
        if (held) begin
            chk("hold_valid", out_valid_o, 1);
            chk("hold_pix", pix_o, held_pix);
        end
        held     = out_valid_o && !out_ready_i;
        held_pix = pix_o;
        next_cv  = 0;
        if (out_valid_o && out_ready_i) begin
            n_out++;
            if (q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                chk("pix", pix_o, e.pix);
                chk("last", last_o, e.last);
`ifdef SOBEL_DIR_EN
                chk("dir", dir_o, e.dir);
                last_dir = dir_o;
`endif
                last_pix = pix_o;
                c = m_cnt;
                if (e.edg && c != CMAX) c++;
                if (e.last) begin
                    m_ec = c;
                    m_cnt = 0;
                    next_cv = 1;
                end else begin
                    m_cnt = c;
                end
            end
        end
        acc = in_valid_i && in_ready_o;
        if (acc) q.push_back(model(win_i, mode_i, int'(thresh_i), last_i));
        m_cv = next_cv;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid_i = 1'b0;
        #2;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_pix", pix_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_edge_cnt", edge_cnt_o, 0);
        chk("rst_cnt_valid", cnt_valid_o, 0);
`ifdef SOBEL_DIR_EN
        chk("rst_dir", dir_o, 0);
`endif
        q.delete();
        m_cnt = 0; m_ec = 0; m_cv = 0; held = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [9*DW-1:0] mkwin(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        logic [9*DW-1:0] w;
        w = {a8[DW-1:0], a7[DW-1:0], a6[DW-1:0], a5[DW-1:0], a4[DW-1:0],
             a3[DW-1:0], a2[DW-1:0], a1[DW-1:0], a0[DW-1:0]};
        return w;
    endfunction

    function automatic logic [9*DW-1:0] rndwin();
        logic [9*DW-1:0] w;
        for (int k = 0; k < 9; k++) begin
            if ($urandom_range(0, 3) == 0)
                w[k*DW +: DW] = ($urandom_range(0, 1) == 1) ? DW'(PMAX) : '0;
            else
                w[k*DW +: DW] = DW'($urandom_range(0, PMAX));
        end
        return w;
    endfunction

    task automatic set_beat(input logic [9*DW-1:0] w, input int m, input int thr, input bit lst);
        win_i      = w;
        mode_i     = 2'(m);
        thresh_i   = (DW+3)'(thr);
        last_i     = lst;
        in_valid_i = 1'b1;
    endtask

    task automatic send(input logic [9*DW-1:0] w, input int m, input int thr, input bit lst);
        int tries = 0;
        set_beat(w, m, thr, lst);
        do begin
            cyc();
            tries++;
        end while (!acc && tries < 50);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        while ((q.size() > 0 || out_valid_o || cnt_valid_o) && n < 100) begin
            cyc();
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    logic [9*DW-1:0] step_w, flat_w, vert_w, diag_w;
    int lat;

    initial begin
        rst_n       = 1'b1;
        win_i       = '0;
        mode_i      = '0;
        thresh_i    = '0;
        last_i      = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        flat_w = mkwin(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
        step_w = mkwin(8'hFF, 0, 0, 8'hFF, 0, 0, 8'hFF, 0, 0);
        vert_w = mkwin(8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0);
        diag_w = mkwin(8'hFF, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        do_reset();
        #1;
        chk("rst_in_ready", in_ready_o, 1);
        @(negedge clk);

        // flat window, latency
        set_beat(flat_w, 0, 0, 0);
        cyc();
        chk("flat_accept", acc, 1);
        in_valid_i = 1'b0;
        lat = 0;
        do begin
            cyc();
            lat++;
        end while (!ov_now && lat < 20);
        chk("latency", lat, 4);
        chk("flat_pix", last_pix, 0);
        drain();

        // worst-case step
        send(step_w, 0, 0, 0);    drain(); chk("step_mode0", last_pix, 255);
        send(step_w, 2, 60, 0);   drain(); chk("step_mode2", last_pix, 255);
        send(step_w, 1, 1021, 0); drain(); chk("step_mode1", last_pix, 0);
        send(step_w, 3, 0, 0);    drain(); chk("step_mode3", last_pix, 255);

`ifdef SOBEL_DIR_EN
        send(step_w, 0, 0, 0); drain(); chk("dir_horiz", last_dir, 0);
        send(vert_w, 0, 0, 0); drain(); chk("dir_vert", last_dir, 1);
        send(diag_w, 0, 0, 0); drain(); chk("dir_diag", last_dir, 2);
`endif

        // stream then stall
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_beat(rndwin(), $urandom_range(0, 3), $urandom_range(0, 1100), 0);
            cyc();
        end
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_beat(rndwin(), $urandom_range(0, 3), $urandom_range(0, 1100), 0);
            #1;
            chk("stall_ready", in_ready_o, 0);
            cyc();
        end
        drain();

        // framed counting, starting from a clean counter
        do_reset();
        pulses = 0;
        for (int i = 1; i <= 10; i++)
            send(step_w, 1, (i == 2 || i == 5 || i == 9) ? 100 : 1021, (i == 10));
        drain();
        repeat (2) cyc();
        chk("frame_cnt", edge_cnt_o, 3);
        chk("frame_pulses", pulses, 1);
        for (int i = 1; i <= 4; i++)
            send(step_w, 1, (i == 3) ? 100 : 1021, (i == 4));
        drain();
        repeat (2) cyc();
        chk("frame2_cnt", edge_cnt_o, 1);
        chk("frame2_pulses", pulses, 2);

        // reset with beats in flight
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_beat(step_w, 1, 100, 0);
            cyc();
        end
        in_valid_i = 1'b0;
        repeat (3) cyc();
        chk("inflight_valid", out_valid_o, 1);
        do_reset();
        n_out = 0;
        out_ready_i = 1'b1;
        repeat (10) cyc();
        chk("no_stale", n_out, 0);

        // counter saturation combined with last
        for (int i = 1; i <= 20; i++) begin
            set_beat(step_w, 0, 0, (i == 20));
            cyc();
        end
        drain();
        repeat (2) cyc();
        chk("sat_cnt", edge_cnt_o, CMAX);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            win_i       = rndwin();
            mode_i      = 2'($urandom_range(0, 3));
            thresh_i    = (DW+3)'($urandom_range(0, 1100));
            last_i      = ($urandom_range(0, 15) == 0);
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 9) < 7);
            cyc();
        end
        drain();
        repeat (2) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
